// File: rtl/vga_top.sv
// vga_top: 640x480@60 Hz VGA timing generator with an 8-bar colour test pattern.
//
// Ports:
//   ice_clk_i  - board/pixel clock, all logic on the rising edge
//   rst_n_i    - asynchronous active-low reset
//   led_o      - 8-bit frame counter
//   hs_o/vs_o  - horizontal/vertical sync, active low, registered
//   red_o, green_o, blue_o - 4-bit colour intensities, registered
//
// Outputs carry one pixel of latency: after each pixel-enable edge they show the
// decode of the counter state that existed before that edge.
module vga_top #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_DIV  = 1,
  parameter int unsigned BAR_W    = 80
) (
  input  logic       ice_clk_i,
  input  logic       rst_n_i,
  output logic [7:0] led_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [9:0]      HLast    = 10'(HTotal - 1);
  localparam logic [9:0]      VLast    = 10'(VTotal - 1);
  localparam logic [9:0]      HActive  = 10'(H_ACTIVE);
  localparam logic [9:0]      VActive  = 10'(V_ACTIVE);
  localparam logic [9:0]      HsStart  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]      HsEnd    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]      VsStart  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]      VsEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]      BarLast  = 10'(BAR_W - 1);
  localparam logic [DivW-1:0] PixLast  = DivW'(PIX_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_cnt_q, h_cnt_d;
  logic [9:0]      v_cnt_q, v_cnt_d;
  logic [7:0]      frame_q, frame_d;
  logic [9:0]      bar_pix_q, bar_pix_d;
  logic [2:0]      bar_q, bar_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic [3:0]      red_q, red_d;
  logic [3:0]      green_q, green_d;
  logic [3:0]      blue_q, blue_d;

  logic pix_en;
  logic active;
  logic h_wrap;

  always_comb begin
    pix_en    = (div_q == PixLast);
    div_d     = pix_en ? '0 : div_q + DivW'(1);
    h_wrap    = (h_cnt_q == HLast);
    active    = (h_cnt_q < HActive) && (v_cnt_q < VActive);

    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    frame_d   = frame_q;
    bar_pix_d = bar_pix_q;
    bar_d     = bar_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;

    if (pix_en) begin
      if (h_wrap) begin
        h_cnt_d   = '0;
        bar_pix_d = '0;
        bar_d     = '0;
        if (v_cnt_q == VLast) begin
          v_cnt_d = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
        if (bar_pix_q == BarLast) begin
          bar_pix_d = '0;
          bar_d     = bar_q + 3'd1;
        end else begin
          bar_pix_d = bar_pix_q + 10'd1;
        end
      end

      hs_d = !((h_cnt_q >= HsStart) && (h_cnt_q < HsEnd));
      vs_d = !((v_cnt_q >= VsStart) && (v_cnt_q < VsEnd));
      // Bar colour bits: R = ~bar[1], G = ~bar[2], B = ~bar[0] gives
      // white, yellow, cyan, green, magenta, red, blue, black.
      red_d   = (active && !bar_q[1]) ? 4'hF : 4'h0;
      green_d = (active && !bar_q[2]) ? 4'hF : 4'h0;
      blue_d  = (active && !bar_q[0]) ? 4'hF : 4'h0;
    end
  end

  always_ff @(posedge ice_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q     <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      frame_q   <= '0;
      bar_pix_q <= '0;
      bar_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      div_q     <= div_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      frame_q   <= frame_d;
      bar_pix_q <= bar_pix_d;
      bar_q     <= bar_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign led_o   = frame_q;
  assign hs_o    = hs_q;
  assign vs_o    = vs_q;
  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;

endmodule

// File: tb/tb_vga_top.sv
// tb_vga_top: drives three vga_top instances from one clock/reset -- full-size timing,
// a shrunken frame (fast enough for 256-frame LED wrap) and the shrunken frame with a
// pixel divider of 2 -- and compares every output against an arithmetic reference.
module tb_vga_top;

  logic clk;
  logic rst_n;

  logic [7:0] led_a, led_b, led_c;
  logic       hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  int checks = 0;
  int errors = 0;
  int n      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_top u_full (
    .ice_clk_i(clk), .rst_n_i(rst_n), .led_o(led_a), .hs_o(hs_a), .vs_o(vs_a),
    .red_o(r_a), .green_o(g_a), .blue_o(b_a)
  );

  vga_top #(
    .H_ACTIVE(24), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIX_DIV(1), .BAR_W(3)
  ) u_small (
    .ice_clk_i(clk), .rst_n_i(rst_n), .led_o(led_b), .hs_o(hs_b), .vs_o(vs_b),
    .red_o(r_b), .green_o(g_b), .blue_o(b_b)
  );

  vga_top #(
    .H_ACTIVE(24), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIX_DIV(2), .BAR_W(3)
  ) u_div2 (
    .ice_clk_i(clk), .rst_n_i(rst_n), .led_o(led_c), .hs_o(hs_c), .vs_o(vs_c),
    .red_o(r_c), .green_o(g_c), .blue_o(b_c)
  );

  localparam logic [21:0] ResetVec = {8'h00, 1'b1, 1'b1, 12'h000};

  function automatic logic [11:0] bar_rgb(input int bar);
    case (bar)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Expected {led, hs, vs, rgb} after clock edge k since reset release.
  function automatic logic [21:0] model(input int ha, input int hf, input int hsw, input int hb,
                                        input int va, input int vf, input int vsw, input int vb,
                                        input int bw, input int div, input int k);
    int m, ht, vt, ft, p, h, v;
    logic hs_n, vs_n;
    logic [11:0] rgb;
    logic [7:0] led;
    m  = k / div;
    if (m == 0) return ResetVec;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ft = ht * vt;
    p  = (m - 1) % ft;
    h  = p % ht;
    v  = p / ht;
    led  = 8'((m / ft) % 256);
    hs_n = !(h >= ha + hf && h < ha + hf + hsw);
    vs_n = !(v >= va + vf && v < va + vf + vsw);
    rgb  = (h < ha && v < va) ? bar_rgb(h / bw) : 12'h000;
    return {led, hs_n, vs_n, rgb};
  endfunction

  task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    if (n < 2500)
      check("full", {led_a, hs_a, vs_a, r_a, g_a, b_a},
            model(640, 16, 96, 48, 480, 10, 2, 33, 80, 1, n));
    check("small", {led_b, hs_b, vs_b, r_b, g_b, b_b},
          model(24, 2, 4, 2, 4, 1, 1, 1, 3, 1, n));
    check("div2", {led_c, hs_c, vs_c, r_c, g_c, b_c},
          model(24, 2, 4, 2, 4, 1, 1, 1, 3, 2, n));
  endtask

  task automatic check_reset(input string tag);
    checks += 3;
    assert ({led_a, hs_a, vs_a, r_a, g_a, b_a} === ResetVec) else begin
      errors++;
      $error("FAIL %s_full observed=%h expected=%h", tag, {led_a, hs_a, vs_a, r_a, g_a, b_a},
             ResetVec);
    end
    assert ({led_b, hs_b, vs_b, r_b, g_b, b_b} === ResetVec) else begin
      errors++;
      $error("FAIL %s_small observed=%h expected=%h", tag, {led_b, hs_b, vs_b, r_b, g_b, b_b},
             ResetVec);
    end
    assert ({led_c, hs_c, vs_c, r_c, g_c, b_c} === ResetVec) else begin
      errors++;
      $error("FAIL %s_div2 observed=%h expected=%h", tag, {led_c, hs_c, vs_c, r_c, g_c, b_c},
             ResetVec);
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n++;
      check_all();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
  endtask

  initial begin
    int hold;
    int len;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check_reset("por");

    release_reset();
    // 256 small frames (224 clocks each) plus margin covers the LED wrap 255 -> 0.
    run(256 * 224 + 300);

    for (int r = 0; r < 2; r++) begin
      len = int'($urandom_range(40, 700));
      run(len);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("async_rst");
      hold = int'($urandom_range(1, 8));
      repeat (hold) @(negedge clk);
      check_reset("rst_hold");
      release_reset();
      run(2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_top.md
Name: vga_top

Overview:
- Top level of the VGA demo.
- Generates 640x480@60 Hz VGA timing (800x525 total) from the board clock and drives 4-bit-per-channel RGB with an 8-bar colour test pattern.
- Shows an 8-bit frame counter on the LEDs.
- Sits directly on the FPGA pins; no sub-interfaces other than clock and reset.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 1, ice_clk_i cycles per pixel (1 = every clock is a pixel)
- BAR_W, 80, colour bar width (pixels)

Ports:
- ice_clk_i  in  1  board/pixel clock, all logic on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- led_o  out  8  frame counter bits [7:0]
- hs_o  out  1  horizontal sync, active low
- vs_o  out  1  vertical sync, active low
- red_o  out  4  red intensity
- green_o  out  4  green intensity
- blue_o  out  4  blue intensity

Behaviour:

Reset (rst_n_i=0, asynchronous):
- h_cnt=0, v_cnt=0, frame counter=0, divider=0.
- hs_o=1, vs_o=1, red_o=green_o=blue_o=0, led_o=0.
- Counting starts on the first rising edge after release.

Pixel enable:
- Divider counts 0..PIX_DIV-1 and asserts pix_en when it equals PIX_DIV-1.
- With PIX_DIV=1, pix_en is always 1.
- Counters and outputs change only on pix_en cycles.

Counters:
- H_TOTAL = sum of H params = 800; V_TOTAL = sum of V params = 525.
- h_cnt: 0..H_TOTAL-1 (10 bits), wraps to 0.
- v_cnt: 0..V_TOTAL-1 (10 bits). Increments when h_cnt wraps; wraps to 0 when at V_TOTAL-1 and h_cnt wraps.
- Frame counter: 8 bits, increments on the same cycle v_cnt wraps. Modulo 256.

Decode, combinational from the current counters:
- active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- hs_n low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vs_n low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.

Pattern:
- bar index = h_cnt/BAR_W (0..7), implemented with a bar counter reset at h_cnt=0 or compare chain; no divider.
- Bar colours (R,G,B):
  - 0: F,F,F white
  - 1: F,F,0 yellow
  - 2: 0,F,F cyan
  - 3: 0,F,0 green
  - 4: F,0,F magenta
  - 5: F,0,0 red
  - 6: 0,0,F blue
  - 7: 0,0,0 black
- Outside active, RGB = 0.

Output registers:
- hs_o, vs_o, red_o, green_o, blue_o and led_o are registered.
- One pixel of latency: the value appearing after the pix_en edge corresponds to the counter state before that edge.
- Sync and RGB stay mutually aligned.

Boundaries:
- Sync never asserts during active video.
- h_cnt=639 → last bar-7 pixel; h_cnt=640 → RGB 0.
- Reset mid-frame restarts at pixel (0,0) with outputs at reset values.

Test Plan:
1. Hold rst_n_i=0 for 10 clocks → hs_o=vs_o=1, RGB=0, led_o=0. Release → first registered pixel (0,0) gives RGB F,F,F one clock later.
2. Run one line, PIX_DIV=1 → hs_o low exactly 96 clocks per line, falling edge 657 clocks after line start (656 + 1 latency). Line period is 800 clocks.
3. Sample RGB across line 0 → F,F,F at h 0..79, F,F,0 at h 80..159, … 0,0,0 at h 560..639. RGB 0 at h 640..799.
4. Run one full frame of 420000 clocks → vs_o low for 2 lines (1600 clocks) starting at v_cnt=490. led_o goes 0→1 at the frame wrap.
5. Run 256 frames (or force the counter) → led_o wraps 255→0. Assert rst_n_i mid-line → outputs return to reset values immediately, without waiting for a clock edge.
6. PIX_DIV=2 → all timing doubles: line = 1600 clocks, hs_o low for 192 clocks.
